vga_sync_controller: RTL and testbench
======================================

// Module: vga_sync_controller
// PURPOSE
//   Sequences the VGA raster: divides the system clock down to a pixel tick and
//   runs the horizontal counter. Drives the one-cycle enable_v pulse that steps
//   the external vertical line counter, and decodes that counter's v_count.
//   Produces hsync, vsync, video_on, pixel x/y and a frame_start strobe for the
//   pixel generator.
// PARAMETERS
//   CLK_DIV   4    sys clocks per pixel (>=2); 100 MHz -> 25 MHz pixel rate
//   H_ACTIVE  640  visible pixels per line
//   H_FRONT   16   horizontal front porch, pixels
//   H_SYNC    96   hsync pulse width, pixels
//   H_BACK    48   horizontal back porch, pixels (H_TOTAL = sum = 800)
//   V_ACTIVE  480  visible lines
//   V_FRONT   10   vertical front porch, lines
//   V_SYNC    2    vsync pulse width, lines
//   V_BACK    33   vertical back porch, lines (V_TOTAL = 525)
// PORTS
//   clk          in   1   system clock, all logic on posedge
//   reset        in   1   asynchronous, active-high reset
//   v_count      in   10  current line from the vertical counter
//   enable_v     out  1   1-clk pulse: step the vertical counter
//   pixel_tick   out  1   1-clk pulse, once every CLK_DIV clocks
//   h_count      out  10  current pixel column, 0..H_TOTAL-1
//   hsync        out  1   horizontal sync, active low
//   vsync        out  1   vertical sync, active low
//   video_on     out  1   1 while (h_count,v_count) is in the visible area
//   x            out  10  = h_count when video_on, else 0
//   y            out  10  = v_count when video_on, else 0
//   frame_start  out  1   1-clk pulse at pixel (0,0)
// BEHAVIOUR
//   Reset (async): div=0, h_count=0, state=H_ACT, pixel_tick=0, enable_v=0,
//   frame_start=0, video_on=0, x=y=0, hsync=1, vsync=1.
//   Reset mid-line or mid-frame clears everything immediately. No partial
//   pulses appear after release.
//   Divider: div counts 0..CLK_DIV-1 and wraps. pixel_tick=1 for the clk where
//   div==CLK_DIV-1 (registered). The first tick comes CLK_DIV clks after reset
//   release.
//   h_count advances only on pixel_tick. It wraps from H_TOTAL-1 to 0.
//   enable_v: registered 1-clk pulse on the tick where h_count wraps
//   H_TOTAL-1 -> 0. Never wider than 1 clk, because the vertical counter
//   increments on every clk it sees enable_v high.
//   Horizontal FSM; states change only on pixel_tick, decoded from next h_count:
//     H_ACT   h < H_ACTIVE                   -> H_FP at h==H_ACTIVE
//     H_FP    H_ACTIVE .. +H_FRONT-1         -> H_SYNC at h==H_ACTIVE+H_FRONT
//     H_SYNC  next H_SYNC pixels, hsync=0    -> H_BP at end of sync
//     H_BP    remainder to H_TOTAL-1         -> H_ACT on wrap to 0
//   Unreachable state encodings return to H_ACT on the next pixel_tick.
//   hsync, video_on, x and frame_start are registered together with h_count,
//   so all of them are aligned with h_count (0 clk skew between them).
//   vsync=0 iff V_ACTIVE+V_FRONT <= v_count < V_ACTIVE+V_FRONT+V_SYNC.
//   vsync is registered from v_count and lags it by 1 clk.
//   video_on = (state==H_ACT) && (v_count < V_ACTIVE).
//   v_count >= V_TOTAL is treated as blanking: video_on=0, vsync=1.
//   frame_start is asserted on the pixel_tick where next h_count==0 and
//   v_count==0, i.e. once per frame.
//   Widths: all counters are 10 bits unsigned. Compares use parameter sums
//   computed as localparams.
// TESTING
//   Reset: hold reset 3 clks -> hsync=vsync=1, h_count=0, all pulses 0;
//   release -> first pixel_tick at clk 4.
//   Divider: 40 clks free-run -> pixel_tick exactly 10 times, 4 clks apart,
//   each 1 clk wide.
//   Line wrap: h_count 799 + tick -> h_count=0 and enable_v=1 for exactly
//   1 clk; no other enable_v in 800 ticks.
//   hsync: over one line -> hsync=0 for h_count 656..751 (96 ticks) and 1
//   elsewhere.
//   Visible area: v_count=479 gives video_on 1 at h=639 and 0 at h=640;
//   v_count=480 gives video_on 0 at h=0; x and y are 0 when video_on=0.
//   vsync and frame: drive v_count 489,490,491,492 -> vsync 1,0,0,1 (1-clk
//   lag); v_count=0 at wrap -> frame_start 1 clk.
//   Mid-operation reset at h_count=300, v_count=100 -> outputs return to reset
//   values asynchronously.

Source files
------------

// File: rtl/vga_sync_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sync_controller_if
//  Description : Bundle of raster timing signals between the VGA sync
//                controller (master) and its consumers (slave): the external
//                vertical line counter and the pixel generator.
//                  v_count     line number from the vertical counter
//                  enable_v    1-clk step request to the vertical counter
//                  pixel_tick  1-clk pixel-rate strobe
//                  h_count     current pixel column
//                  hsync/vsync active-low sync outputs
//                  video_on    visible-area flag
//                  x, y        visible coordinates (0 during blanking)
//                  frame_start 1-clk strobe at pixel (0,0)
//  Revision    : 1.0  initial release
// ============================================================================
interface vga_sync_controller_if;
    logic [9:0] v_count;
    logic       enable_v;
    logic       pixel_tick;
    logic [9:0] h_count;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [9:0] x;
    logic [9:0] y;
    logic       frame_start;

    modport master (
        input  v_count,
        output enable_v, pixel_tick, h_count, hsync, vsync,
               video_on, x, y, frame_start
    );

    modport slave (
        output v_count,
        input  enable_v, pixel_tick, h_count, hsync, vsync,
               video_on, x, y, frame_start
    );
endinterface
`default_nettype wire

// File: rtl/vga_sync_controller.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sync_controller
//  Description : VGA raster sequencer. Divides clk down to a pixel tick, runs
//                the horizontal pixel counter and its porch/sync FSM, pulses
//                enable_v at each line wrap to step an external vertical
//                counter, and decodes that counter's v_count into vsync,
//                video_on, y and frame_start.
//  Ports       : clk    system clock (posedge)
//                reset  asynchronous active-high reset
//                bus    vga_sync_controller_if.master (see interface file)
//  Revision    : 1.0  initial release
// ============================================================================
module vga_sync_controller #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33
) (
    input  wire logic               clk,
    input  wire logic               reset,
    vga_sync_controller_if.master   bus
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_FP_START   = 10'(H_ACTIVE);
    localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] H_BP_START   = 10'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [9:0] H_LAST       = 10'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_VIS_END    = 10'(V_ACTIVE);
    localparam logic [9:0] VS_START     = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] VS_END       = 10'(V_ACTIVE + V_FRONT + V_SYNC);
    // Frame length is implied: any v_count outside [0,V_ACTIVE) and outside the
    // sync window already decodes as blanking with vsync high.
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    typedef enum logic [1:0] {
        ST_H_ACT  = 2'd0,
        ST_H_FP   = 2'd1,
        ST_H_SYNC = 2'd2,
        ST_H_BP   = 2'd3
    } h_state_t;

    h_state_t         r_state;
    h_state_t         w_state_nxt;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_nxt;
    logic             w_tick;
    logic [9:0]       r_h_count;
    logic [9:0]       w_h_nxt;
    logic             w_video_nxt;
    logic             w_vsync_nxt;
    logic             w_line_wrap;
    logic             r_pixel_tick;
    logic             r_enable_v;
    logic             r_frame_start;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_video_on;
    logic [9:0]       r_x;
    logic [9:0]       r_y;

    // Next-state and next-output decode. Everything tied to h_count is
    // computed from the *next* column so the registered outputs line up
    // with h_count in the same cycle.
    always_comb begin
        w_tick      = (r_div == DIV_LAST);
        w_div_nxt   = w_tick ? '0 : r_div + DIV_W'(1);
        w_h_nxt     = (r_h_count == H_LAST) ? 10'd0 : r_h_count + 10'd1;
        w_line_wrap = (w_h_nxt == 10'd0);

        w_state_nxt = r_state;
        case (r_state)
            ST_H_ACT:  if (w_h_nxt == H_FP_START)   w_state_nxt = ST_H_FP;
            ST_H_FP:   if (w_h_nxt == H_SYNC_START) w_state_nxt = ST_H_SYNC;
            ST_H_SYNC: if (w_h_nxt == H_BP_START)   w_state_nxt = ST_H_BP;
            ST_H_BP:   if (w_line_wrap)             w_state_nxt = ST_H_ACT;
            default:                                w_state_nxt = ST_H_ACT;
        endcase

        // Lines at or beyond V_TOTAL fall outside both ranges below and so
        // read as blanking with vsync inactive.
        w_video_nxt = (w_state_nxt == ST_H_ACT) && (bus.v_count < V_VIS_END);
        w_vsync_nxt = !((bus.v_count >= VS_START) && (bus.v_count < VS_END));
    end

    // Horizontal FSM state register; advances only on the pixel tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_H_ACT;
        end else if (w_tick) begin
            r_state <= w_state_nxt;
        end
    end

    // Divider, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div         <= '0;
            r_h_count     <= 10'd0;
            r_pixel_tick  <= 1'b0;
            r_enable_v    <= 1'b0;
            r_frame_start <= 1'b0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_video_on    <= 1'b0;
            r_x           <= 10'd0;
            r_y           <= 10'd0;
        end else begin
            r_div         <= w_div_nxt;
            r_pixel_tick  <= w_tick;
            // Strobes are re-evaluated every clk so they drop after one cycle.
            r_enable_v    <= w_tick && w_line_wrap;
            r_frame_start <= w_tick && w_line_wrap && (bus.v_count == 10'd0);
            r_vsync       <= w_vsync_nxt;
            if (w_tick) begin
                r_h_count  <= w_h_nxt;
                r_hsync    <= (w_state_nxt != ST_H_SYNC);
                r_video_on <= w_video_nxt;
                r_x        <= w_video_nxt ? w_h_nxt : 10'd0;
                r_y        <= w_video_nxt ? bus.v_count : 10'd0;
            end
        end
    end

    assign bus.pixel_tick  = r_pixel_tick;
    assign bus.enable_v    = r_enable_v;
    assign bus.frame_start = r_frame_start;
    assign bus.h_count     = r_h_count;
    assign bus.hsync       = r_hsync;
    assign bus.vsync       = r_vsync;
    assign bus.video_on    = r_video_on;
    assign bus.x           = r_x;
    assign bus.y           = r_y;

    // Elaboration-time sanity on the geometry.
    if (CLK_DIV < 2) begin : g_bad_div
        $error("CLK_DIV must be at least 2");
    end
    if (V_TOTAL > 1024 || (H_ACTIVE + H_FRONT + H_SYNC + H_BACK) > 1024) begin : g_bad_total
        $error("raster totals must fit 10-bit counters");
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_sync_controller
//  Description : Self-checking bench for vga_sync_controller. A reference
//                model derives every output from the number of clocks since
//                reset release (pixel = clocks/CLK_DIV mod 800) and the
//                v_count values seen at clock edges; directed sequences add
//                hand-computed literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vga_sync_controller;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    vga_sync_controller_if vif ();

    vga_sync_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (vif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_edges = 0;     // clock edges since reset release
    int m_vline = 1023;  // v_count seen at the most recent pixel tick
    int m_vsv   = 0;     // v_count seen at the most recent clock edge

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_edges = 0;
            m_vline = 1023;
            m_vsv   = 0;
        end else begin
            m_edges = m_edges + 1;
            m_vsv   = int'(vif.v_count);
            if (m_edges % 4 == 0) m_vline = int'(vif.v_count);
        end
    end

    int e_tick, e_h, e_vis, e_hs, e_vs;
    always @(posedge clk) begin
        #1;
        e_tick = (m_edges > 0 && m_edges % 4 == 0) ? 1 : 0;
        e_h    = (m_edges / 4) % 800;
        e_vis  = (e_h < 640 && m_vline < 480) ? 1 : 0;
        e_hs   = (e_h >= 656 && e_h < 752) ? 0 : 1;
        e_vs   = (m_vsv >= 490 && m_vsv < 492) ? 0 : 1;
        check("m_pixel_tick", int'(vif.pixel_tick), e_tick);
        check("m_h_count", int'(vif.h_count), e_h);
        check("m_enable_v", int'(vif.enable_v), (e_tick == 1 && e_h == 0) ? 1 : 0);
        check("m_frame_start", int'(vif.frame_start),
              (e_tick == 1 && e_h == 0 && m_vline == 0) ? 1 : 0);
        check("m_hsync", int'(vif.hsync), e_hs);
        check("m_vsync", int'(vif.vsync), e_vs);
        check("m_video_on", int'(vif.video_on), e_vis);
        check("m_x", int'(vif.x), (e_vis == 1) ? e_h : 0);
        check("m_y", int'(vif.y), (e_vis == 1) ? m_vline : 0);
    end

    // ---------------- directed helpers ----------------
    task automatic wait_tick_h(input int h);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 4000 && !found; i++) begin
            @(negedge clk);
            if (vif.pixel_tick && int'(vif.h_count) == h) found = 1'b1;
        end
        check("wait_tick_h", int'(found), 1);
    endtask

    // ---------------- directed stimulus ----------------
    int n, cnt, hmin, hmax;
    bit found;
    int vs_in  [4] = '{489, 490, 491, 492};
    int vs_exp [4] = '{1, 0, 0, 1};

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        vif.v_count = 10'd0;

        // Reset held for 3 clocks.
        repeat (3) @(negedge clk);
        check("rst_hsync", int'(vif.hsync), 1);
        check("rst_vsync", int'(vif.vsync), 1);
        check("rst_h_count", int'(vif.h_count), 0);
        check("rst_pixel_tick", int'(vif.pixel_tick), 0);
        check("rst_enable_v", int'(vif.enable_v), 0);
        check("rst_frame_start", int'(vif.frame_start), 0);
        reset = 1'b0;

        // First tick comes on the 4th clock after release.
        n = 0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (vif.pixel_tick) found = 1'b1;
        end
        check("first_tick_clk", n, 4);

        // Any 40 consecutive clocks hold exactly 10 ticks.
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cnt += int'(vif.pixel_tick);
        end
        check("ticks_in_40", cnt, 10);

        // Line wrap: 799 -> 0 with a single-clock enable_v.
        wait_tick_h(799);
        wait_tick_h(0);
        check("wrap_enable_v", int'(vif.enable_v), 1);
        @(negedge clk);
        check("wrap_enable_v_drop", int'(vif.enable_v), 0);
        cnt = 0;
        for (int i = 0; i < 3200; i++) begin
            @(negedge clk);
            cnt += int'(vif.enable_v);
        end
        check("enable_v_per_line", cnt, 1);

        // hsync low for columns 656..751 only.
        cnt  = 0;
        hmin = 9999;
        hmax = -1;
        for (int i = 0; i < 3200; i++) begin
            @(negedge clk);
            if (vif.pixel_tick && !vif.hsync) begin
                cnt++;
                if (int'(vif.h_count) < hmin) hmin = int'(vif.h_count);
                if (int'(vif.h_count) > hmax) hmax = int'(vif.h_count);
            end
        end
        check("hsync_low_ticks", cnt, 96);
        check("hsync_first_col", hmin, 656);
        check("hsync_last_col", hmax, 751);

        // Visible-area edges.
        vif.v_count = 10'd479;
        wait_tick_h(639);
        check("vis_479_639_on", int'(vif.video_on), 1);
        check("vis_479_639_x", int'(vif.x), 639);
        check("vis_479_639_y", int'(vif.y), 479);
        wait_tick_h(640);
        check("vis_479_640_on", int'(vif.video_on), 0);
        check("vis_479_640_x", int'(vif.x), 0);
        check("vis_479_640_y", int'(vif.y), 0);
        vif.v_count = 10'd480;
        wait_tick_h(0);
        check("vis_480_0_on", int'(vif.video_on), 0);
        check("vis_480_0_y", int'(vif.y), 0);

        // vsync decode with one clock of lag; out-of-range line is blanking.
        for (int i = 0; i < 4; i++) begin
            vif.v_count = 10'(vs_in[i]);
            @(negedge clk);
            check("vsync_seq", int'(vif.vsync), vs_exp[i]);
        end
        vif.v_count = 10'd600;
        @(negedge clk);
        check("vsync_beyond_total", int'(vif.vsync), 1);

        // frame_start at pixel (0,0).
        vif.v_count = 10'd0;
        wait_tick_h(0);
        check("frame_start_on", int'(vif.frame_start), 1);
        @(negedge clk);
        check("frame_start_drop", int'(vif.frame_start), 0);

        // Asynchronous reset mid-line.
        vif.v_count = 10'd100;
        found = 1'b0;
        for (int i = 0; i < 4000 && !found; i++) begin
            @(negedge clk);
            if (int'(vif.h_count) == 300) found = 1'b1;
        end
        check("reach_h300", int'(found), 1);
        check("pre_rst_video_on", int'(vif.video_on), 1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_h_count", int'(vif.h_count), 0);
        check("arst_hsync", int'(vif.hsync), 1);
        check("arst_vsync", int'(vif.vsync), 1);
        check("arst_video_on", int'(vif.video_on), 0);
        check("arst_x", int'(vif.x), 0);
        check("arst_y", int'(vif.y), 0);
        check("arst_pixel_tick", int'(vif.pixel_tick), 0);
        check("arst_enable_v", int'(vif.enable_v), 0);
        check("arst_frame_start", int'(vif.frame_start), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
